// File: rtl/uart_reg_master_pkg.sv
// rtl/uart_reg_master_pkg.sv - shared encodings for the UART register master
package uart_reg_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND_ADDR = 3'd1,
    ST_SEND_DATA = 3'd2,
    ST_WAIT_RSP  = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  localparam int RW_BIT     = 7;
  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

  // Command byte: address in the low bits, bit RW_BIT set for a read.
  function automatic logic [7:0] addr_byte(input logic write, input logic [6:0] addr);
    logic [7:0] r;
    r         = {1'b0, addr};
    r[RW_BIT] = ~write;
    return r;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and start-bit strobe
module uart_rx
  import uart_reg_master_pkg::*;
#(
  parameter int CLKS_PER_BIT = 142
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] tdata,
  output logic       tvalid,
  output logic       start
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = $clog2(FRAME_BITS);

  logic                 rx_meta, rx_sync;
  logic                 active, wait_high;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;

  // After a framing error the line must return high before a new start is accepted.
  assign start = !active && !wait_high && !rx_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      active    <= 1'b0;
      wait_high <= 1'b0;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      tdata     <= '0;
      tvalid    <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      tvalid  <= 1'b0;
      if (start) begin
        active  <= 1'b1;
        cnt     <= CW'(CLKS_PER_BIT / 2);
        bit_idx <= '0;
      end else if (active) begin
        if (cnt != CW'(CLKS_PER_BIT - 1)) begin
          cnt <= cnt + CW'(1);
        end else begin
          cnt <= '0;
          if (bit_idx == '0) begin
            if (rx_sync) active <= 1'b0;
            else         bit_idx <= BW'(1);
          end else if (bit_idx != BW'(FRAME_BITS - 1)) begin
            shreg   <= {rx_sync, shreg[DATA_BITS-1:1]};
            bit_idx <= bit_idx + BW'(1);
          end else begin
            active  <= 1'b0;
            bit_idx <= '0;
            if (rx_sync) begin
              tvalid <= 1'b1;
              tdata  <= shreg;
            end else begin
              wait_high <= 1'b1;
            end
          end
        end
      end else if (wait_high && rx_sync) begin
        wait_high <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter, LSB first, reloads back-to-back on the stop-bit end
module uart_tx
  import uart_reg_master_pkg::*;
#(
  parameter int CLKS_PER_BIT = 142
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tdata,
  input  logic       tvalid,
  output logic       tready,
  output logic       tx,
  output logic       done
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = $clog2(FRAME_BITS);

  logic                 active;
  logic [CW-1:0]        clk_cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS:0]   shreg;
  logic                 bit_end;

  assign bit_end = (clk_cnt == CW'(CLKS_PER_BIT - 1));
  assign done    = active && bit_end && (bit_idx == BW'(FRAME_BITS - 1));
  // Accepting on the last stop-bit cycle lets the next start bit follow with no gap.
  assign tready  = !active || done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active  <= 1'b0;
      clk_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else if (tvalid && tready) begin
      active  <= 1'b1;
      clk_cnt <= '0;
      bit_idx <= '0;
      shreg   <= {1'b1, tdata};
      tx      <= 1'b0;
    end else if (done) begin
      active  <= 1'b0;
      clk_cnt <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
    end else if (active) begin
      if (bit_end) begin
        clk_cnt <= '0;
        bit_idx <= bit_idx + BW'(1);
        tx      <= shreg[0];
        shreg   <= {1'b1, shreg[DATA_BITS:1]};
      end else begin
        clk_cnt <= clk_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_reg_master.sv
// rtl/uart_reg_master.sv - register read/write master over a UART link
module uart_reg_master
  import uart_reg_master_pkg::*;
#(
  parameter int CLKS_PER_BIT     = 142,
  parameter int RSP_TIMEOUT_CLKS = 4260
) (
  input  logic       clk_in,
  input  logic       rst_in_n,
  input  logic       req_valid_in,
  output logic       req_ready_out,
  input  logic       req_write_in,
  input  logic [6:0] req_addr_in,
  input  logic [7:0] req_wdata_in,
  output logic       tx_out,
  input  logic       rx_in,
  output logic       rsp_valid_out,
  output logic [7:0] rsp_rdata_out,
  output logic       rsp_timeout_out,
  output logic       busy_out
);

  localparam int TW = $clog2(RSP_TIMEOUT_CLKS + 1);

  state_t        state, state_next;
  logic          write_q, loaded;
  logic [6:0]    addr_q;
  logic [7:0]    wdata_q, rdata_q;
  logic          timeout_q, to_hit;
  logic [TW-1:0] to_cnt;
  logic          tx_tvalid, tx_tready, tx_done;
  logic [7:0]    tx_tdata;
  logic          rx_tvalid, rx_start;
  logic [7:0]    rx_tdata;

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk(clk_in), .rst_n(rst_in_n), .tdata(tx_tdata), .tvalid(tx_tvalid),
    .tready(tx_tready), .tx(tx_out), .done(tx_done)
  );

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk(clk_in), .rst_n(rst_in_n), .rx(rx_in), .tdata(rx_tdata),
    .tvalid(rx_tvalid), .start(rx_start)
  );

  // A start bit seen on the expiry cycle wins over the timeout.
  assign to_hit = (to_cnt == TW'(RSP_TIMEOUT_CLKS - 1)) && !rx_start;

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) state <= ST_IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:      if (req_valid_in) state_next = ST_SEND_ADDR;
      ST_SEND_ADDR: if (tx_done) state_next = write_q ? ST_SEND_DATA : ST_WAIT_RSP;
      ST_SEND_DATA: if (tx_done) state_next = ST_DONE;
      ST_WAIT_RSP:  if (rx_tvalid || to_hit) state_next = ST_DONE;
      ST_DONE:      state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready_out = (state == ST_IDLE);
    busy_out      = (state != ST_IDLE);
    rsp_valid_out = (state == ST_DONE);
    tx_tvalid     = (state == ST_SEND_ADDR) && (!loaded || (write_q && tx_done));
    tx_tdata      = loaded ? wdata_q : addr_byte(write_q, addr_q);
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      loaded    <= 1'b0;
      to_cnt    <= '0;
      rdata_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == ST_IDLE && req_valid_in) begin
        write_q <= req_write_in;
        addr_q  <= req_addr_in;
        wdata_q <= req_wdata_in;
      end
      loaded <= (state_next == ST_SEND_ADDR) && (loaded || (tx_tvalid && tx_tready));
      if (state != ST_WAIT_RSP || rx_start) to_cnt <= '0;
      else                                  to_cnt <= to_cnt + TW'(1);
      if (state == ST_SEND_DATA && tx_done) begin
        rdata_q   <= '0;
        timeout_q <= 1'b0;
      end else if (state == ST_WAIT_RSP && rx_tvalid) begin
        rdata_q   <= rx_tdata;
        timeout_q <= 1'b0;
      end else if (state == ST_WAIT_RSP && to_hit) begin
        rdata_q   <= '0;
        timeout_q <= 1'b1;
      end
    end
  end

  assign rsp_rdata_out   = rdata_q;
  assign rsp_timeout_out = timeout_q;

endmodule

// File: tb/tb_uart_reg_master.sv
// tb/tb_uart_reg_master.sv - bench with UART register-bank responder and reference model
module tb_uart_reg_master;

  localparam int CPB = 8;
  localparam int TO  = 240;

  logic       clk_in = 1'b0;
  logic       rst_in_n = 1'b0;
  logic       req_valid_in = 1'b0, req_write_in = 1'b0;
  logic [6:0] req_addr_in = '0;
  logic [7:0] req_wdata_in = '0;
  logic       req_ready_out, tx_out, rx_in, rsp_valid_out, rsp_timeout_out, busy_out;
  logic [7:0] rsp_rdata_out;
  logic       rx_main = 1'b1, rx_resp = 1'b1;

  assign rx_in = rx_main & rx_resp;
  always #5 clk_in = ~clk_in;

  uart_reg_master #(.CLKS_PER_BIT(CPB), .RSP_TIMEOUT_CLKS(TO)) dut (
    .clk_in(clk_in), .rst_in_n(rst_in_n), .req_valid_in(req_valid_in),
    .req_ready_out(req_ready_out), .req_write_in(req_write_in), .req_addr_in(req_addr_in),
    .req_wdata_in(req_wdata_in), .tx_out(tx_out), .rx_in(rx_in),
    .rsp_valid_out(rsp_valid_out), .rsp_rdata_out(rsp_rdata_out),
    .rsp_timeout_out(rsp_timeout_out), .busy_out(busy_out)
  );

  int cyc = 0;
  int rst_count = 0;
  int n_run = 0, n_fail = 0;
  int resp_mode = 0;  // 0 reply, 1 silent, 2 reply with bad stop bit
  logic [7:0] txb_q[$];
  logic       txs_q[$];
  int         txc_q[$];
  logic [7:0] rsp_d_q[$];
  logic       rsp_t_q[$];
  int         rsp_c_q[$];

  always @(posedge clk_in) cyc <= cyc + 1;
  always @(negedge rst_in_n) rst_count <= rst_count + 1;
  always @(negedge clk_in)
    if (rst_in_n === 1'b1 && rsp_valid_out === 1'b1) begin
      rsp_d_q.push_back(rsp_rdata_out);
      rsp_t_q.push_back(rsp_timeout_out);
      rsp_c_q.push_back(cyc);
    end

  function automatic logic [7:0] init_val(input int a);
    return (a == 7) ? 8'hBA : 8'(a * 37 + 11);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Register-bank side: decodes tx bytes, applies writes, answers reads.
  initial begin : bank_model
    logic [7:0] bank [128];
    logic [7:0] b;
    logic [9:0] fr;
    logic       stop, wp;
    logic [6:0] wa;
    int         sc, rc;
    for (int i = 0; i < 128; i++) bank[i] = init_val(i);
    wp = 1'b0; wa = '0; b = '0;
    forever begin
      @(posedge clk_in); #1;
      if (rst_in_n === 1'b1 && tx_out === 1'b0) begin
        sc = cyc; rc = rst_count;
        repeat (CPB / 2) @(posedge clk_in);
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) @(posedge clk_in); #1;
          b[k] = tx_out;
        end
        repeat (CPB) @(posedge clk_in); #1;
        stop = tx_out;
        if (rc != rst_count || rst_in_n !== 1'b1) begin
          wp = 1'b0;
        end else begin
          txb_q.push_back(b); txs_q.push_back(stop); txc_q.push_back(sc);
          if (wp) begin
            bank[wa] = b; wp = 1'b0;
          end else if (!b[7]) begin
            wp = 1'b1; wa = b[6:0];
          end else if (resp_mode != 1) begin
            fr = {(resp_mode == 2) ? 1'b0 : 1'b1, bank[b[6:0]], 1'b0};
            repeat (CPB / 2 + int'($urandom_range(1, 8))) @(posedge clk_in);
            for (int k = 0; k < 10; k++) begin
              rx_resp = fr[k];
              repeat (CPB) @(posedge clk_in);
            end
            rx_resp = 1'b1;
          end
        end
      end
    end
  end

  task automatic do_req(input logic w, input logic [6:0] a, input logic [7:0] wd,
                        output int acc, output logic ok);
    int k;
    @(negedge clk_in);
    req_write_in = w; req_addr_in = a; req_wdata_in = wd; req_valid_in = 1'b1;
    k = 0;
    while (req_ready_out !== 1'b1 && k < 2000) begin @(negedge clk_in); k++; end
    ok = (req_ready_out === 1'b1);
    @(posedge clk_in); #1;
    acc = cyc;
    req_valid_in = 1'b0; req_write_in = ~w; req_addr_in = ~a; req_wdata_in = ~wd;
  endtask

  task automatic wait_tx(input int n, output logic ok);
    int k;
    k = 0;
    while (txb_q.size() < n && k < 40 * CPB + TO) begin @(posedge clk_in); k++; end
    ok = (txb_q.size() >= n);
  endtask

  task automatic wait_rsp(input int n, input int bound, output logic ok);
    int k;
    k = 0;
    while (rsp_d_q.size() < n && k < bound) begin @(posedge clk_in); k++; end
    ok = (rsp_d_q.size() >= n);
  endtask

  task automatic send_rx_main(input logic [7:0] v);
    logic [9:0] fr;
    fr = {1'b1, v, 1'b0};
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_in); rx_main = fr[k];
      repeat (CPB - 1) @(negedge clk_in);
    end
    @(negedge clk_in); rx_main = 1'b1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : main
    logic [7:0] exp_regs [128];
    logic [7:0] exp_rd [200];
    logic [7:0] wd;
    logic [6:0] a;
    logic       ok, w;
    int         acc, txi, ri, ds, d, k, base;
    for (int i = 0; i < 128; i++) exp_regs[i] = init_val(i);

    repeat (5) @(posedge clk_in);
    @(negedge clk_in);
    check("rst_tx", tx_out, 1);
    check("rst_ready", req_ready_out, 1);
    check("rst_busy", busy_out, 0);
    check("rst_rsp_valid", rsp_valid_out, 0);
    check("rst_rdata", rsp_rdata_out, 0);
    check("rst_timeout", rsp_timeout_out, 0);
    rst_in_n = 1'b1;
    repeat (3) @(negedge clk_in);

    // write addr 3 <- 0xA5
    txi = txb_q.size(); ri = rsp_d_q.size();
    do_req(1'b1, 7'd3, 8'hA5, acc, ok);
    check("wr_accept", ok, 1);
    wait_tx(txi + 2, ok);
    check("wr_tx_seen", ok, 1);
    check("wr_byte0", txb_q[txi], 8'h03);
    check("wr_byte1", txb_q[txi+1], 8'hA5);
    check("wr_stops", {txs_q[txi], txs_q[txi+1]}, 2'b11);
    check("wr_start_latency", (txc_q[txi] - acc >= 1) && (txc_q[txi] - acc <= 2), 1);
    check("wr_back_to_back", txc_q[txi+1] - txc_q[txi], 10 * CPB);
    wait_rsp(ri + 1, 40 * CPB, ok);
    check("wr_rsp_seen", ok, 1);
    check("wr_rdata", rsp_d_q[ri], 8'h00);
    check("wr_timeout", rsp_t_q[ri], 0);
    d = rsp_c_q[ri] - (txc_q[txi+1] + 10 * CPB);
    check("wr_rsp_latency", (d >= 0) && (d <= 2), 1);
    repeat (10 * CPB) @(negedge clk_in);
    check("wr_one_pulse", rsp_d_q.size(), ri + 1);
    exp_regs[3] = 8'hA5;

    // read addr 7, bank replies 0xBA
    txi = txb_q.size(); ri = rsp_d_q.size();
    do_req(1'b0, 7'd7, 8'h00, acc, ok);
    wait_tx(txi + 1, ok);
    check("rd_byte", txb_q[txi], 8'h87);
    wait_rsp(ri + 1, 40 * CPB + 2 * TO, ok);
    check("rd_rsp_seen", ok, 1);
    check("rd_rdata", rsp_d_q[ri], exp_regs[7]);
    check("rd_timeout", rsp_t_q[ri], 0);

    // read addr 2, bank silent
    resp_mode = 1;
    txi = txb_q.size(); ri = rsp_d_q.size();
    do_req(1'b0, 7'd2, 8'h00, acc, ok);
    wait_tx(txi + 1, ok);
    check("to_byte", txb_q[txi], 8'h82);
    wait_rsp(ri + 1, 40 * CPB + 2 * TO, ok);
    check("to_rsp_seen", ok, 1);
    check("to_flag", rsp_t_q[ri], 1);
    check("to_rdata", rsp_d_q[ri], 8'h00);
    d = rsp_c_q[ri] - (txc_q[txi] + 10 * CPB);
    check("to_latency", (d >= TO - 2) && (d <= TO + 2), 1);
    resp_mode = 0;

    // spurious byte while idle, then a normal read
    ri = rsp_d_q.size();
    send_rx_main(8'h55);
    repeat (4 * CPB) @(negedge clk_in);
    check("spur_no_rsp", rsp_d_q.size(), ri);
    txi = txb_q.size();
    do_req(1'b0, 7'd3, 8'h00, acc, ok);
    wait_rsp(ri + 1, 40 * CPB + 2 * TO, ok);
    check("spur_rd_seen", ok, 1);
    check("spur_rd_rdata", rsp_d_q[ri], exp_regs[3]);
    check("spur_rd_timeout", rsp_t_q[ri], 0);

    // read addr 5, reply with a bad stop bit -> timeout
    resp_mode = 2;
    ri = rsp_d_q.size();
    do_req(1'b0, 7'd5, 8'h00, acc, ok);
    wait_rsp(ri + 1, 60 * CPB + 2 * TO, ok);
    check("badstop_rsp_seen", ok, 1);
    check("badstop_timeout", rsp_t_q[ri], 1);
    check("badstop_rdata", rsp_d_q[ri], 8'h00);
    resp_mode = 0;

    // reset during data bit 4 of a write (bit 4 of 0xC3 is 0)
    txi = txb_q.size(); ri = rsp_d_q.size();
    do_req(1'b1, 7'd9, 8'hC3, acc, ok);
    wait_tx(txi + 1, ok);
    ds = txc_q[txi] + 10 * CPB;
    k = 0;
    while (cyc < ds + 5 * CPB + CPB / 2 && k < 40 * CPB) begin @(posedge clk_in); k++; end
    check("mid_bit4_low", tx_out, 0);
    #2 rst_in_n = 1'b0;
    #1;
    check("mid_rst_tx", tx_out, 1);
    check("mid_rst_ready", req_ready_out, 1);
    check("mid_rst_busy", busy_out, 0);
    check("mid_rst_rdata", rsp_rdata_out, 0);
    repeat (3) @(negedge clk_in);
    rst_in_n = 1'b1;
    repeat (20 * CPB) @(negedge clk_in);
    check("mid_no_rsp", rsp_d_q.size(), ri);
    check("mid_byte_aborted", txb_q.size(), txi + 1);
    check("mid_tx_idle", tx_out, 1);

    // back-to-back: 100 write/read pairs with req_valid_in held high
    base = rsp_d_q.size();
    @(negedge clk_in);
    req_valid_in = 1'b1;
    for (int i = 0; i < 200; i++) begin
      w  = (i % 2 == 0);
      a  = 7'($urandom_range(0, 15));
      wd = 8'($urandom);
      if (w) begin exp_regs[a] = wd; exp_rd[i] = 8'h00; end
      else   exp_rd[i] = exp_regs[a];
      req_write_in = w; req_addr_in = a; req_wdata_in = wd;
      k = 0;
      while (req_ready_out !== 1'b1 && k < 2000) begin @(negedge clk_in); k++; end
      if (req_ready_out !== 1'b1) begin
        check("b2b_ready", req_ready_out, 1);
        break;
      end
      @(negedge clk_in);
    end
    req_valid_in = 1'b0;
    wait_rsp(base + 200, 2000, ok);
    check("b2b_all_seen", ok, 1);
    for (int i = 0; i < 200 && base + i < rsp_d_q.size(); i++) begin
      check($sformatf("b2b_rdata_%0d", i), rsp_d_q[base+i], exp_rd[i]);
      check($sformatf("b2b_timeout_%0d", i), rsp_t_q[base+i], 0);
    end
    repeat (20 * CPB) @(negedge clk_in);
    check("b2b_count", rsp_d_q.size(), base + 200);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
